shift_rows_pipe: RTL and testbench

//  Parametrised, registered successor to the fixed 128-bit ShiftRows permutation. Supports Rijndael block widths NB=4/6/8 columns.

---
 rtl/aes_pkg.sv | 11 +
 rtl/shift_rows_perm.sv | 23 ++
 rtl/shift_rows_pipe.sv | 62 ++++++
 tb/tb_shift_rows_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared ShiftRows helpers plus the mode and handshake-state types.
package aes_pkg;
  typedef enum logic {SR_FWD = 1'b0, SR_INV = 1'b1} mode_e;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  function automatic int shift_off(input int nb, input int r);
    return (nb == 8 && r >= 2) ? r + 1 : r;
  endfunction
  function automatic int byte_lsb(input int nb, input int r, input int c);
    return 32 * nb - 8 - 8 * (4 * c + r);
  endfunction
endpackage

// File: rtl/shift_rows_perm.sv
// shift_rows_perm: combinational Rijndael (Inv)ShiftRows for NB = 4, 6 or 8 columns.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4,
  localparam int BW = 32 * NB
) (
  input  logic          inv,
  input  logic [BW-1:0] din,
  output logic [BW-1:0] dout
);
  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $fatal(1, "shift_rows_perm: NB must be 4, 6 or 8");
  end
  for (genvar r = 0; r < 4; r++) begin : g_r
    for (genvar c = 0; c < NB; c++) begin : g_c
      localparam int DST = byte_lsb(NB, r, c);
      localparam int FWD = byte_lsb(NB, r, (c + shift_off(NB, r)) % NB);
      localparam int INV = byte_lsb(NB, r, (c - shift_off(NB, r) + NB) % NB);
      assign dout[DST +: 8] = (mode_e'(inv) == SR_INV) ? din[INV +: 8] : din[FWD +: 8];
    end
  end
endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: registered (Inv)ShiftRows stage with valid/ready handshake and a one-entry skid buffer.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4,
  localparam int BW   = 32 * NB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [BW-1:0]    in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW-1:0]    out_data,
  output logic [TAG_W-1:0] out_tag
);
  logic [BW-1:0]    perm, main_q, main_d, skid_q, skid_d;
  logic [TAG_W-1:0] mtag_q, mtag_d, stag_q, stag_d;
  state_e           state_q, state_d;
  logic             rdy_q, acc, drain, load_main, load_skid, pop_skid;
  shift_rows_perm #(.NB(NB)) u_perm (.inv(in_inv), .din(in_data), .dout(perm));
  // rdy_q keeps the input closed for the first edge after reset release
  assign in_ready  = rdy_q && state_q != TWO;
  assign out_valid = state_q != EMPTY;
  assign out_data  = main_q;
  assign out_tag   = mtag_q;
  assign acc       = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign load_main = acc && (state_q == EMPTY || (state_q == ONE && drain));
  assign load_skid = acc && state_q == ONE && !drain;
  assign pop_skid  = state_q == TWO && drain;
  always_comb begin
    main_d  = pop_skid ? skid_q : load_main ? perm : main_q;
    mtag_d  = pop_skid ? stag_q : load_main ? in_tag : mtag_q;
    skid_d  = load_skid ? perm : pop_skid ? '0 : skid_q;
    stag_d  = load_skid ? in_tag : pop_skid ? '0 : stag_q;
    state_d = state_q == EMPTY ? (acc ? ONE : EMPTY)
            : state_q == ONE   ? (load_skid ? TWO : (drain && !acc) ? EMPTY : ONE)
            : (drain ? ONE : TWO);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
      main_q  <= '0;
      mtag_q  <= '0;
      skid_q  <= '0;
      stag_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      main_q  <= main_d;
      mtag_q  <= mtag_d;
      skid_q  <= skid_d;
      stag_q  <= stag_d;
    end
  end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: directed table vectors plus handshake, throughput and reset sequences.
module tb_shift_rows_pipe;
  typedef struct {
    int           nb;
    logic         inv;
    logic [255:0] din;
    logic [255:0] exp;
  } vec_t;
  logic         clk = 1'b0, rst_n, in_valid, in_inv, out_ready;
  logic [3:0]   in_tag;
  logic [255:0] din;
  logic         rdy4, rdy6, rdy8, ov4, ov6, ov8;
  logic [127:0] od4;
  logic [191:0] od6;
  logic [255:0] od8;
  logic [3:0]   ot4, ot6, ot8;
  int           total = 0, passed = 0;
  vec_t         tv[8];
  logic [127:0] bpd[1:8];
  logic [255:0] p4, p6, p8, r8, r6;
  int           nin, nexp, nout, occ, cyc, drops, bad;
  logic         acc, drn, stall;
  logic [127:0] prev_d;
  logic [3:0]   prev_t;

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4),
    .in_inv(in_inv), .in_data(din[127:0]), .in_tag(in_tag), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .out_tag(ot4));
  shift_rows_pipe #(.NB(6), .TAG_W(4)) dut6 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy6),
    .in_inv(in_inv), .in_data(din[191:0]), .in_tag(in_tag), .out_valid(ov6), .out_ready(out_ready),
    .out_data(od6), .out_tag(ot6));
  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_inv(in_inv), .in_data(din), .in_tag(in_tag), .out_valid(ov8), .out_ready(out_ready),
    .out_data(od8), .out_tag(ot8));

  function automatic int pos(input int nb, input int r, input int c);
    return 32 * nb - 8 - 8 * (4 * c + r);
  endfunction

  function automatic logic [255:0] model(input logic [255:0] d, input int nb, input logic inv);
    logic [255:0] o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) begin
        int off = (nb == 8 && r > 1) ? r + 1 : r;
        int s = inv ? (c - off + nb) % nb : (c + off) % nb;
        o[pos(nb, r, c) +: 8] = d[pos(nb, r, s) +: 8];
      end
    return o;
  endfunction

  function automatic logic [255:0] pattern(input int nb);
    logic [255:0] o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) o[pos(nb, r, c) +: 8] = 8'(8 * c + r);
    return o;
  endfunction

  function automatic logic [7:0] gb(input logic [255:0] d, input int nb, input int r, input int c);
    return d[pos(nb, r, c) +: 8];
  endfunction

  function automatic logic [255:0] outn(input int nb);
    return nb == 4 ? {128'b0, od4} : nb == 6 ? {64'b0, od6} : od8;
  endfunction

  function automatic logic [3:0] tagn(input int nb);
    return nb == 4 ? ot4 : nb == 6 ? ot6 : ot8;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic beat(input logic [255:0] d, input logic inv, input logic [3:0] tag);
    din = d; in_inv = inv; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    p4 = pattern(4); p6 = pattern(6); p8 = pattern(8);
    tv[0] = '{4, 1'b0, 256'hd42711ae_e0bf98f1_b8b45de5_1e415230, 256'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
    tv[1] = '{4, 1'b1, 256'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 256'hd42711ae_e0bf98f1_b8b45de5_1e415230};
    tv[2] = '{8, 1'b0, p8, model(p8, 8, 1'b0)};
    tv[3] = '{8, 1'b1, model(p8, 8, 1'b0), p8};
    tv[4] = '{6, 1'b0, p6, model(p6, 6, 1'b0)};
    tv[5] = '{6, 1'b1, model(p6, 6, 1'b0), p6};
    tv[6] = '{4, 1'b1, p4, model(p4, 4, 1'b1)};
    tv[7] = '{4, 1'b0, model(p4, 4, 1'b1), p4};
    for (int i = 1; i <= 8; i++) bpd[i] = {$urandom, $urandom, $urandom, $urandom};
    rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; out_ready = 1'b0; in_tag = '0; din = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", 256'(ov4), 256'(0));
    chk("rst_out_data", 256'(od4), 256'(0));
    chk("rst_out_tag", 256'(ot4), 256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 256'(rdy4), 256'(1));

    for (int i = 0; i < 8; i++) begin
      beat(tv[i].din, tv[i].inv, 4'(i));
      chk($sformatf("vec%0d_data", i), outn(tv[i].nb), tv[i].exp);
      chk($sformatf("vec%0d_tag", i), 256'(tagn(tv[i].nb)), 256'(i));
      @(posedge clk); #1;
    end

    beat(p8, 1'b0, 4'd9);
    r8 = od8; r6 = {64'b0, od6};
    chk("nb8_r3c0", 256'(gb(r8, 8, 3, 0)), 256'h23);
    chk("nb8_r1c0", 256'(gb(r8, 8, 1, 0)), 256'h09);
    chk("nb8_r2c0", 256'(gb(r8, 8, 2, 0)), 256'h1a);
    chk("nb8_r2c6", 256'(gb(r8, 8, 2, 6)), 256'h0a);
    chk("nb8_r0c5", 256'(gb(r8, 8, 0, 5)), 256'h28);
    chk("nb8_r1c7", 256'(gb(r8, 8, 1, 7)), 256'h01);
    @(posedge clk); #1;
    beat(p6, 1'b0, 4'd10);
    r6 = {64'b0, od6};
    chk("nb6_r3c0", 256'(gb(r6, 6, 3, 0)), 256'h1b);
    chk("nb6_r2c5", 256'(gb(r6, 6, 2, 5)), 256'h0a);
    chk("nb6_r1c5", 256'(gb(r6, 6, 1, 5)), 256'h01);
    @(posedge clk); #1;

    nin = 1; nexp = 1; occ = 0; cyc = 0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    while (nexp <= 8 && cyc < 400) begin
      if (!in_valid && nin <= 8 && $urandom_range(1) == 1) begin
        in_valid = 1'b1; in_tag = 4'(nin); din = {128'b0, bpd[nin]}; in_inv = nin[0];
      end
      out_ready = $urandom_range(1) == 1;
      @(negedge clk);
      chk("bp_in_ready", 256'(rdy4), 256'(occ < 2));
      if (stall) begin
        chk("bp_stable_data", 256'(od4), 256'(prev_d));
        chk("bp_stable_tag", 256'(ot4), 256'(prev_t));
      end
      acc = in_valid && rdy4;
      drn = ov4 && out_ready;
      if (drn) begin
        chk("bp_tag", 256'(ot4), 256'(nexp));
        chk("bp_data", 256'(od4), model({128'b0, bpd[nexp]}, 4, nexp[0]));
      end
      stall = ov4 && !out_ready; prev_d = od4; prev_t = ot4;
      @(posedge clk); #1;
      if (acc) begin in_valid = 1'b0; nin++; occ++; end
      if (drn) begin nexp++; occ--; end
      cyc++;
    end
    chk("bp_all_out", 256'(nexp), 256'(9));
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    nin = 0; nout = 0; cyc = 0; drops = 0; bad = 0;
    in_inv = 1'b0; in_valid = 1'b1; in_tag = 4'(0); din = {128'b0, {4{32'(0)}}};
    while (nout < 100 && cyc < 150) begin
      @(negedge clk);
      cyc++;
      if (!rdy4) drops++;
      acc = in_valid && rdy4;
      if (ov4) begin
        if (ot4 !== 4'(nout) || od4 !== model({128'b0, {4{32'(nout)}}}, 4, 1'b0)) bad++;
        nout++;
      end
      @(posedge clk); #1;
      if (acc) nin++;
      in_valid = nin < 100; in_tag = 4'(nin); din = {128'b0, {4{32'(nin)}}};
    end
    chk("tp_beats_out", 256'(nout), 256'(100));
    chk("tp_beats_in", 256'(nin), 256'(100));
    chk("tp_ready_drops", 256'(drops), 256'(0));
    chk("tp_bad_beats", 256'(bad), 256'(0));
    chk("tp_cycles", 256'(cyc), 256'(101));
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    out_ready = 1'b0; in_inv = 1'b0;
    in_valid = 1'b1; din = {128'b0, bpd[1]}; in_tag = 4'd1;
    @(posedge clk); #1;
    din = {128'b0, bpd[2]}; in_tag = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold2_in_ready", 256'(rdy4), 256'(0));
    chk("hold2_out_valid", 256'(ov4), 256'(1));
    chk("hold2_out_tag", 256'(ot4), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 256'(ov4), 256'(0));
    chk("async_rst_data", 256'(od4), 256'(0));
    @(posedge clk); #1;
    in_valid = 1'b1; din = {128'b0, bpd[3]}; in_tag = 4'd5; in_inv = 1'b1; out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_no_accept", 256'(ov4), 256'(0));
    chk("release_in_ready", 256'(rdy4), 256'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_rst_valid", 256'(ov4), 256'(1));
    chk("post_rst_data", 256'(od4), model({128'b0, bpd[3]}, 4, 1'b1));
    chk("post_rst_tag", 256'(ot4), 256'(5));
    @(posedge clk); #1;
    chk("post_rst_drained", 256'(ov4), 256'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
